lsu_bus_arbiter: RTL and testbench
==================================

// Module: lsu_bus_arbiter
// PURPOSE
//  Shares the single LSU/data-memory port between two requesters: m0 = CPU data port, m1 = debug/program loader.
//  Arbitrates each request and sequences fixed-latency reads. Returns read data only to the requester that issued the read.
//  Sits between core/loader and lsu; the LSU sees one master.
// PARAMETERS
//  ADDR_W  16  byte address width driven to LSU
//  DATA_W  32  data width
//  RD_LAT  1   cycles from accept to valid s_rdata (>=1)
// PORTS
//  clk       in   1       clock, all logic on posedge
//  rst_n     in   1       synchronous reset, active-low
//  mN_req    in   1       N=0,1: request; hold with addr/data/we/mode stable until mN_gnt
//  mN_we     in   1       1=write, 0=read
//  mN_addr   in   ADDR_W  byte address
//  mN_wdata  in   DATA_W  store data
//  mN_mode   in   3       data_mode (byte/half/word, signed/unsigned) passed to LSU
//  mN_gnt    out  1       request accepted this cycle
//  mN_rvld   out  1       read data valid, 1-cycle pulse
//  mN_rdata  out  DATA_W  read data, valid when mN_rvld
//  s_en      out  1       LSU access strobe (read or write)
//  s_we      out  1       LSU write enable
//  s_addr    out  ADDR_W  to LSU
//  s_wdata   out  DATA_W  to LSU
//  s_mode    out  3       to LSU
//  s_rdata   in   DATA_W  from LSU, valid RD_LAT cycles after accept
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE, lat_cnt=0, last_owner=m1, all outputs 0.
//  FSM states: IDLE, RD_WAIT.
//  IDLE:
//   - Winner chosen combinationally from mN_req. m0 wins the first conflict after reset.
//   - Winner's mN_gnt=1 in the same cycle. s_en=1; s_* muxed from the winner.
//   - Write: done in the accept cycle. Stay IDLE; next grant possible in the next cycle (1 write/cycle).
//   - Read: load lat_cnt=RD_LAT-1, latch owner, then go to RD_WAIT.
//  RD_WAIT:
//   - No grants; s_en=0.
//   - When lat_cnt==0: owner's rvld=1 and rdata=s_rdata, then go to IDLE. Otherwise lat_cnt-1.
//   - Read accepted in cycle T: rvld in cycle T+RD_LAT; next grant earliest at T+RD_LAT+1.
//  Non-owner rvld stays 0 and its rdata holds 0. mN_rdata is 0 whenever rvld=0.
//  last_owner updates on every accept, reads and writes alike.
//  Default arbitration is 2-way round robin: on a conflict the requester that is not last_owner wins.
//  No request in IDLE: s_en=0, s_addr/s_wdata/s_mode=0, gnt=0.
//  A request that drops before gnt is discarded; no state change.
//  A requester may request again in the cycle its own rvld fires; it is arbitrated in the next IDLE cycle.
//  Reset mid-read: the transaction is abandoned and no rvld is issued; the requester must re-issue.
//  lat_cnt width = $clog2(RD_LAT+1); no wrap occurs since it only counts down from RD_LAT-1.
// CONFIGURATION
//  LSU_ARB_FIXED_PRIO_EN defined: fixed priority, m0 always wins a conflict; last_owner is not used for choice.
//  Not defined: round robin as above.
// STRUCTURE
//  Shared defines header (alongside the CPU defines):
//   - FSM state encodings ARB_IDLE/ARB_RD_WAIT
//   - owner encodings ARB_OWN_M0/ARB_OWN_M1
//   - DATA_MODE_* constants, reused from the CPU header
//  Sub-module rr_pick2: inputs req[1:0] and last; output one-hot gnt[1:0]. Combinational; holds the prio macro switch.
//  Top: FSM, lat_cnt, owner/last_owner registers, s_* mux, response demux.
// TESTING
//  1 Reset: rst_n=0 for 2 clk with m0_req=m1_req=1 -> all gnt/rvld/s_en=0; after release, m0_gnt=1 in the first cycle.
//  2 Conflicting writes: both request writes to 0x7000/0x7004 held 4 cycles -> gnt alternates m0,m1,m0,m1; s_addr follows.
//  3 Read latency: RD_LAT=3, m1 read of 0x0010 at T -> m1_rvld only at T+3 with s_rdata; m0 request at T+1 is granted no earlier than T+4.
//  4 Macro on: both request continuously -> m0_gnt every cycle (writes), m1 starved; macro off -> alternates.
//  5 Reset mid-read: rst_n=0 at T+1 of an RD_LAT=2 read -> no rvld ever, state IDLE, next request granted normally.
//  6 Back-to-back single master: m0 write,write,read,write -> gnt at T,T+1,T+2,T+2+RD_LAT+1; s_we matches each.

Source files
------------

// File: rtl/lsu_bus_arbiter_pkg.sv
// rtl/lsu_bus_arbiter_pkg.sv - shared types and constants for the LSU bus arbiter
//
// Purpose:
//   Common encodings used by the arbiter, its requester/memory interfaces
//   and anything that talks to the LSU data port.
//   - arb_state_e  : arbiter FSM states (ARB_IDLE / ARB_RD_WAIT)
//   - arb_owner_e  : requester identity (ARB_OWN_M0 = CPU, ARB_OWN_M1 = loader)
//   - data_mode_e  : LSU access size / sign-extension encodings, the same
//                    values the CPU core drives on its data_mode bus
//   - ARB_MODE_W   : width of the data_mode field
// Ports: none (package).

package lsu_bus_arbiter_pkg;

    localparam int ARB_MODE_W = 3;

    typedef enum logic {
        ARB_IDLE    = 1'b0,
        ARB_RD_WAIT = 1'b1
    } arb_state_e;

    typedef enum logic {
        ARB_OWN_M0 = 1'b0,
        ARB_OWN_M1 = 1'b1
    } arb_owner_e;

    // Bit 2 selects zero-extension on loads; bits 1:0 select the access size.
    typedef enum logic [ARB_MODE_W-1:0] {
        DATA_MODE_BYTE   = 3'b000,
        DATA_MODE_HALF   = 3'b001,
        DATA_MODE_WORD   = 3'b010,
        DATA_MODE_BYTE_U = 3'b100,
        DATA_MODE_HALF_U = 3'b101
    } data_mode_e;

    // Identity of the requester selected by a one-hot grant vector.
    function automatic arb_owner_e arb_owner_of(input logic [1:0] gnt);
        return gnt[1] ? ARB_OWN_M1 : ARB_OWN_M0;
    endfunction

endpackage

// File: rtl/lsu_bus_arbiter_if.sv
// rtl/lsu_bus_arbiter_if.sv - requester-side and LSU-side bus interfaces
//
// Purpose:
//   lsu_bus_arbiter_if : one requester port (CPU data port or loader).
//     req/we/addr/wdata/mode : request, held stable until gnt
//     gnt                    : request accepted this cycle
//     rvld/rdata             : 1-cycle read response; rdata is 0 when rvld=0
//     modport master = requester, modport slave = arbiter
//   lsu_mem_if : the single LSU data-memory port.
//     en/we/addr/wdata/mode  : access strobe and payload
//     rdata                  : read data, valid RD_LAT cycles after accept
//     modport master = arbiter, modport slave = LSU

interface lsu_bus_arbiter_if
    import lsu_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic                  req;
    logic                  we;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [ARB_MODE_W-1:0] mode;
    logic                  gnt;
    logic                  rvld;
    logic [DATA_W-1:0]     rdata;

    modport master (
        output req, we, addr, wdata, mode,
        input  gnt, rvld, rdata
    );

    modport slave (
        input  req, we, addr, wdata, mode,
        output gnt, rvld, rdata
    );
endinterface

interface lsu_mem_if
    import lsu_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic                  en;
    logic                  we;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [ARB_MODE_W-1:0] mode;
    logic [DATA_W-1:0]     rdata;

    modport master (
        output en, we, addr, wdata, mode,
        input  rdata
    );

    modport slave (
        input  en, we, addr, wdata, mode,
        output rdata
    );
endinterface

// File: rtl/lsu_bus_arbiter_rr_pick2.sv
// rtl/lsu_bus_arbiter_rr_pick2.sv - two-way request picker (round robin or fixed priority)
//
// Purpose:
//   Combinational winner selection between two requesters.
//   Build option LSU_ARB_FIXED_PRIO_EN: when defined, requester 0 always wins
//   a conflict and `last` is ignored; when undefined, the requester that did
//   not win last time wins a conflict.
// Ports:
//   req[1:0] in  : request lines (bit 0 = m0, bit 1 = m1)
//   last     in  : requester accepted most recently
//   gnt[1:0] out : one-hot winner, all-zero when nobody requests

module lsu_bus_arbiter_rr_pick2
    import lsu_bus_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  arb_owner_e last,
    output logic [1:0] gnt
);

`ifdef LSU_ARB_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = (last == ARB_OWN_M1);

    always_comb begin
        gnt = 2'b00;
        if (req[0]) begin
            gnt = 2'b01;
        end else if (req[1]) begin
            gnt = 2'b10;
        end
    end
`else
    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            // Conflict: the one that was not served last goes first.
            gnt = (last == ARB_OWN_M0) ? 2'b10 : 2'b01;
        end else begin
            gnt = req;
        end
    end
`endif

endmodule

// File: rtl/lsu_bus_arbiter.sv
// rtl/lsu_bus_arbiter.sv - shares the LSU data port between the CPU (m0) and the loader (m1)
//
// Purpose:
//   Grants one access per cycle while idle, forwards the winner's request to
//   the LSU, and for reads waits RD_LAT cycles before returning s.rdata to the
//   requester that issued it. Writes complete in their accept cycle.
//   Build option LSU_ARB_FIXED_PRIO_EN selects fixed priority (m0 wins) instead
//   of round robin; see lsu_bus_arbiter_rr_pick2.
// Parameters:
//   ADDR_W : byte address width
//   DATA_W : data width
//   RD_LAT : cycles from read accept to valid s.rdata (>= 1)
// Ports:
//   clk    in  : clock, all state on posedge
//   rst_n  in  : synchronous reset, active-low; forces all outputs to 0
//   m0     if  : CPU data port (slave side of lsu_bus_arbiter_if)
//   m1     if  : debug/program loader port (slave side of lsu_bus_arbiter_if)
//   s      if  : LSU port (master side of lsu_mem_if)

module lsu_bus_arbiter
    import lsu_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    lsu_bus_arbiter_if.slave  m0,
    lsu_bus_arbiter_if.slave  m1,
    lsu_mem_if.master         s
);

    localparam int CNT_W = $clog2(RD_LAT + 1);
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(RD_LAT - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    arb_state_e       state_q,      state_d;
    logic [CNT_W-1:0] lat_cnt_q,    lat_cnt_d;
    arb_owner_e       owner_q,      owner_d;
    arb_owner_e       last_owner_q, last_owner_d;

    // ------------------------------------------------------------------
    // Winner selection and request mux
    // ------------------------------------------------------------------
    logic [1:0]            pick_gnt;
    arb_owner_e            win;
    logic                  win_we;
    logic [ADDR_W-1:0]     win_addr;
    logic [DATA_W-1:0]     win_wdata;
    logic [ARB_MODE_W-1:0] win_mode;

    lsu_bus_arbiter_rr_pick2 u_pick (
        .req  ({m1.req, m0.req}),
        .last (last_owner_q),
        .gnt  (pick_gnt)
    );

    assign win       = arb_owner_of(pick_gnt);
    assign win_we    = (win == ARB_OWN_M1) ? m1.we    : m0.we;
    assign win_addr  = (win == ARB_OWN_M1) ? m1.addr  : m0.addr;
    assign win_wdata = (win == ARB_OWN_M1) ? m1.wdata : m0.wdata;
    assign win_mode  = (win == ARB_OWN_M1) ? m1.mode  : m0.mode;

    // ------------------------------------------------------------------
    // Combinational outputs
    // ------------------------------------------------------------------
    logic [1:0]            gnt_c;
    logic [1:0]            rvld_c;
    logic [DATA_W-1:0]     rdata0_c;
    logic [DATA_W-1:0]     rdata1_c;
    logic                  s_en_c;
    logic                  s_we_c;
    logic [ADDR_W-1:0]     s_addr_c;
    logic [DATA_W-1:0]     s_wdata_c;
    logic [ARB_MODE_W-1:0] s_mode_c;

    always_comb begin
        state_d      = state_q;
        lat_cnt_d    = lat_cnt_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;

        gnt_c     = 2'b00;
        rvld_c    = 2'b00;
        rdata0_c  = '0;
        rdata1_c  = '0;
        s_en_c    = 1'b0;
        s_we_c    = 1'b0;
        s_addr_c  = '0;
        s_wdata_c = '0;
        s_mode_c  = '0;

        case (state_q)
            ARB_IDLE: begin
                if (pick_gnt != 2'b00) begin
                    gnt_c        = pick_gnt;
                    s_en_c       = 1'b1;
                    s_we_c       = win_we;
                    s_addr_c     = win_addr;
                    s_wdata_c    = win_wdata;
                    s_mode_c     = win_mode;
                    last_owner_d = win;
                    if (!win_we) begin
                        // Count covers the cycles between accept and data;
                        // RD_LAT=1 loads 0 so data returns in the next cycle.
                        state_d   = ARB_RD_WAIT;
                        lat_cnt_d = LAT_LOAD;
                        owner_d   = win;
                    end
                end
            end

            ARB_RD_WAIT: begin
                if (lat_cnt_q == '0) begin
                    if (owner_q == ARB_OWN_M1) begin
                        rvld_c[1] = 1'b1;
                        rdata1_c  = s.rdata;
                    end else begin
                        rvld_c[0] = 1'b1;
                        rdata0_c  = s.rdata;
                    end
                    state_d = ARB_IDLE;
                end else begin
                    lat_cnt_d = lat_cnt_q - CNT_W'(1);
                end
            end

            default: begin
                state_d = ARB_IDLE;
            end
        endcase

        // While reset is asserted nothing is granted or returned, so a
        // read in flight is dropped without a response.
        if (!rst_n) begin
            gnt_c     = 2'b00;
            rvld_c    = 2'b00;
            rdata0_c  = '0;
            rdata1_c  = '0;
            s_en_c    = 1'b0;
            s_we_c    = 1'b0;
            s_addr_c  = '0;
            s_wdata_c = '0;
            s_mode_c  = '0;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            lat_cnt_q    <= '0;
            owner_q      <= ARB_OWN_M0;
            last_owner_q <= ARB_OWN_M1;   // m0 wins the first conflict
        end else begin
            state_q      <= state_d;
            lat_cnt_q    <= lat_cnt_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
        end
    end

    // ------------------------------------------------------------------
    // Port drive
    // ------------------------------------------------------------------
    assign m0.gnt   = gnt_c[0];
    assign m1.gnt   = gnt_c[1];
    assign m0.rvld  = rvld_c[0];
    assign m1.rvld  = rvld_c[1];
    assign m0.rdata = rdata0_c;
    assign m1.rdata = rdata1_c;

    assign s.en    = s_en_c;
    assign s.we    = s_we_c;
    assign s.addr  = s_addr_c;
    assign s.wdata = s_wdata_c;
    assign s.mode  = s_mode_c;

endmodule

// File: tb/tb_lsu_bus_arbiter.sv
// tb/tb_lsu_bus_arbiter.sv - self-checking bench for lsu_bus_arbiter (RD_LAT=3 and RD_LAT=2 instances)

module tb_lsu_bus_arbiter;
    import lsu_bus_arbiter_pkg::*;

`ifdef LSU_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Requester stimulus shared by both instances
    logic        m_req   [2];
    logic        m_we    [2];
    logic [15:0] m_addr  [2];
    logic [31:0] m_wdata [2];
    logic [2:0]  m_mode  [2];
    logic [31:0] rdata_drv = 32'hA5A5_0000;

    always @(posedge clk) rdata_drv <= rdata_drv + 32'h0101_0103;

    lsu_bus_arbiter_if #(.ADDR_W(16), .DATA_W(32)) ma0 ();
    lsu_bus_arbiter_if #(.ADDR_W(16), .DATA_W(32)) ma1 ();
    lsu_bus_arbiter_if #(.ADDR_W(16), .DATA_W(32)) mb0 ();
    lsu_bus_arbiter_if #(.ADDR_W(16), .DATA_W(32)) mb1 ();
    lsu_mem_if         #(.ADDR_W(16), .DATA_W(32)) sa ();
    lsu_mem_if         #(.ADDR_W(16), .DATA_W(32)) sb ();

    assign ma0.req = m_req[0];   assign mb0.req = m_req[0];
    assign ma0.we = m_we[0];     assign mb0.we = m_we[0];
    assign ma0.addr = m_addr[0]; assign mb0.addr = m_addr[0];
    assign ma0.wdata = m_wdata[0]; assign mb0.wdata = m_wdata[0];
    assign ma0.mode = m_mode[0]; assign mb0.mode = m_mode[0];
    assign ma1.req = m_req[1];   assign mb1.req = m_req[1];
    assign ma1.we = m_we[1];     assign mb1.we = m_we[1];
    assign ma1.addr = m_addr[1]; assign mb1.addr = m_addr[1];
    assign ma1.wdata = m_wdata[1]; assign mb1.wdata = m_wdata[1];
    assign ma1.mode = m_mode[1]; assign mb1.mode = m_mode[1];
    assign sa.rdata = rdata_drv;
    assign sb.rdata = rdata_drv;

    lsu_bus_arbiter #(.ADDR_W(16), .DATA_W(32), .RD_LAT(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .m0(ma0), .m1(ma1), .s(sa)
    );
    lsu_bus_arbiter #(.ADDR_W(16), .DATA_W(32), .RD_LAT(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .m0(mb0), .m1(mb1), .s(sb)
    );

    // Observed outputs, index 0 = dut_a, 1 = dut_b
    logic [1:0]  o_gnt   [2];
    logic [1:0]  o_rvld  [2];
    logic [31:0] o_rd0   [2];
    logic [31:0] o_rd1   [2];
    logic        o_en    [2];
    logic        o_we    [2];
    logic [15:0] o_addr  [2];
    logic [31:0] o_wdata [2];
    logic [2:0]  o_mode  [2];

    assign o_gnt[0] = {ma1.gnt, ma0.gnt};   assign o_gnt[1] = {mb1.gnt, mb0.gnt};
    assign o_rvld[0] = {ma1.rvld, ma0.rvld}; assign o_rvld[1] = {mb1.rvld, mb0.rvld};
    assign o_rd0[0] = ma0.rdata; assign o_rd0[1] = mb0.rdata;
    assign o_rd1[0] = ma1.rdata; assign o_rd1[1] = mb1.rdata;
    assign o_en[0] = sa.en;     assign o_en[1] = sb.en;
    assign o_we[0] = sa.we;     assign o_we[1] = sb.we;
    assign o_addr[0] = sa.addr; assign o_addr[1] = sb.addr;
    assign o_wdata[0] = sa.wdata; assign o_wdata[1] = sb.wdata;
    assign o_mode[0] = sa.mode; assign o_mode[1] = sb.mode;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Transaction-level model: a read accepted in model cycle c returns
    // data in cycle c+lat; the port is busy until then. Evaluated at
    // negedge, where inputs are stable for the coming posedge.
    // ------------------------------------------------------------------
    int lat    [2] = '{3, 2};
    bit busy   [2] = '{0, 0};
    int rv_at  [2] = '{0, 0};
    int own    [2] = '{0, 0};
    int last   [2] = '{1, 1};

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic [1:0]  e_gnt;
            logic [1:0]  e_rvld;
            logic [31:0] e_rd0, e_rd1, e_wdata;
            logic        e_en, e_we;
            logic [15:0] e_addr;
            logic [2:0]  e_mode;
            int          w;
            string       p;
            p = (k == 0) ? "a" : "b";
            e_gnt = 2'b00; e_rvld = 2'b00; e_rd0 = '0; e_rd1 = '0;
            e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0; e_mode = '0;

            if (!rst_n) begin
                busy[k] = 1'b0;
                last[k] = 1;
            end else if (!busy[k]) begin
                w = -1;
                if (m_req[0] && m_req[1])  w = FIXED ? 0 : (last[k] == 0 ? 1 : 0);
                else if (m_req[0])         w = 0;
                else if (m_req[1])         w = 1;
                if (w >= 0) begin
                    e_gnt[w] = 1'b1;
                    e_en     = 1'b1;
                    e_we     = m_we[w];
                    e_addr   = m_addr[w];
                    e_wdata  = m_wdata[w];
                    e_mode   = m_mode[w];
                    last[k]  = w;
                    if (!m_we[w]) begin
                        busy[k]  = 1'b1;
                        own[k]   = w;
                        rv_at[k] = cyc + lat[k];
                    end
                end
            end else if (cyc == rv_at[k]) begin
                e_rvld[own[k]] = 1'b1;
                if (own[k] == 0) e_rd0 = rdata_drv;
                else             e_rd1 = rdata_drv;
                busy[k] = 1'b0;
            end

            chk({p, ".gnt"},   64'(o_gnt[k]),   64'(e_gnt));
            chk({p, ".rvld"},  64'(o_rvld[k]),  64'(e_rvld));
            chk({p, ".rdata0"}, 64'(o_rd0[k]),  64'(e_rd0));
            chk({p, ".rdata1"}, 64'(o_rd1[k]),  64'(e_rd1));
            chk({p, ".s_en"},  64'(o_en[k]),    64'(e_en));
            chk({p, ".s_we"},  64'(o_we[k]),    64'(e_we));
            chk({p, ".s_addr"}, 64'(o_addr[k]), 64'(e_addr));
            chk({p, ".s_wdata"}, 64'(o_wdata[k]), 64'(e_wdata));
            chk({p, ".s_mode"}, 64'(o_mode[k]), 64'(e_mode));
        end
        cyc++;
    end

    // ------------------------------------------------------------------
    // Directed stimulus with hand-computed expectations
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int m, input logic req, input logic we,
                         input logic [15:0] addr, input logic [31:0] wdata,
                         input logic [2:0] mode);
        m_req[m] = req; m_we[m] = we; m_addr[m] = addr;
        m_wdata[m] = wdata; m_mode[m] = mode;
    endtask

    task automatic idle(input int m);
        drive(m, 1'b0, 1'b0, 16'h0, 32'h0, 3'b000);
    endtask

    initial begin
        int exp_w;
        idle(0);
        idle(1);

        // 1: reset held 2 cycles with both requesting
        rst_n = 1'b0;
        drive(0, 1'b1, 1'b1, 16'h7000, 32'h1111_0000, DATA_MODE_WORD);
        drive(1, 1'b1, 1'b1, 16'h7004, 32'h2222_0000, DATA_MODE_HALF);
        repeat (2) begin
            tick();
            #2;
            chk("rst.m0_gnt", 64'(ma0.gnt), 64'd0);
            chk("rst.m1_gnt", 64'(ma1.gnt), 64'd0);
            chk("rst.s_en",   64'(sa.en),   64'd0);
            chk("rst.rvld",   64'({ma1.rvld, ma0.rvld}), 64'd0);
        end
        tick();
        rst_n = 1'b1;
        #2;
        chk("rel.m0_gnt", 64'(ma0.gnt), 64'd1);
        chk("rel.m1_gnt", 64'(ma1.gnt), 64'd0);
        chk("rel.s_addr", 64'(sa.addr), 64'h7000);

        // 2/4: continuous conflicting writes
        for (int i = 1; i < 6; i++) begin
            tick();
            #2;
            exp_w = FIXED ? 0 : (i % 2);
            chk("conf.m0_gnt", 64'(ma0.gnt), 64'(exp_w == 0));
            chk("conf.m1_gnt", 64'(ma1.gnt), 64'(exp_w == 1));
            chk("conf.s_addr", 64'(sa.addr), (exp_w == 0) ? 64'h7000 : 64'h7004);
        end
        tick();
        idle(0);
        idle(1);

        // 3: m1 read with RD_LAT=3, m0 waiting behind it
        tick();
        drive(1, 1'b1, 1'b0, 16'h0010, 32'h0, DATA_MODE_BYTE_U);
        #2;
        chk("lat.T.m1_gnt", 64'(ma1.gnt), 64'd1);
        chk("lat.T.s_mode", 64'(sa.mode), 64'(DATA_MODE_BYTE_U));
        tick();
        idle(1);
        drive(0, 1'b1, 1'b1, 16'h0100, 32'hCAFE_0001, DATA_MODE_WORD);
        #2;
        chk("lat.T1.m0_gnt", 64'(ma0.gnt), 64'd0);
        chk("lat.T1.m1_rvld", 64'(ma1.rvld), 64'd0);
        tick();
        #2;
        chk("lat.T2.m0_gnt", 64'(ma0.gnt), 64'd0);
        chk("lat.T2.m1_rvld", 64'(ma1.rvld), 64'd0);
        tick();
        #2;
        chk("lat.T3.m1_rvld", 64'(ma1.rvld), 64'd1);
        chk("lat.T3.m1_rdata", 64'(ma1.rdata), 64'(rdata_drv));
        chk("lat.T3.m0_rvld", 64'(ma0.rvld), 64'd0);
        chk("lat.T3.m0_gnt", 64'(ma0.gnt), 64'd0);
        tick();
        #2;
        chk("lat.T4.m0_gnt", 64'(ma0.gnt), 64'd1);
        chk("lat.T4.m1_rdata", 64'(ma1.rdata), 64'd0);
        tick();
        idle(0);
        tick();

        // 5: reset during an RD_LAT=2 read on dut_b
        drive(0, 1'b1, 1'b0, 16'h0020, 32'h0, DATA_MODE_HALF);
        #2;
        chk("rmid.m0_gnt", 64'(mb0.gnt), 64'd1);
        tick();
        idle(0);
        rst_n = 1'b0;
        #2;
        chk("rmid.T1.rvld", 64'(mb0.rvld), 64'd0);
        tick();
        rst_n = 1'b1;
        drive(1, 1'b1, 1'b1, 16'h0030, 32'h3333_3333, DATA_MODE_BYTE);
        #2;
        chk("rmid.T2.rvld", 64'(mb0.rvld), 64'd0);
        chk("rmid.T2.m1_gnt", 64'(mb1.gnt), 64'd1);
        tick();
        idle(1);
        #2;
        chk("rmid.T3.rvld", 64'(mb0.rvld), 64'd0);
        tick();

        // 6: back-to-back from m0 alone: write, write, read, write
        drive(0, 1'b1, 1'b1, 16'h0200, 32'h0000_0200, DATA_MODE_WORD);
        #2;
        chk("b2b.T.gnt", 64'(ma0.gnt), 64'd1);
        chk("b2b.T.we",  64'(sa.we),   64'd1);
        tick();
        drive(0, 1'b1, 1'b1, 16'h0204, 32'h0000_0204, DATA_MODE_WORD);
        #2;
        chk("b2b.T1.gnt", 64'(ma0.gnt), 64'd1);
        chk("b2b.T1.we",  64'(sa.we),   64'd1);
        tick();
        drive(0, 1'b1, 1'b0, 16'h0208, 32'h0, DATA_MODE_WORD);
        #2;
        chk("b2b.T2.gnt", 64'(ma0.gnt), 64'd1);
        chk("b2b.T2.we",  64'(sa.we),   64'd0);
        tick();
        drive(0, 1'b1, 1'b1, 16'h020C, 32'h0000_020C, DATA_MODE_HALF);
        #2;
        chk("b2b.T3.gnt", 64'(ma0.gnt), 64'd0);
        tick();
        #2;
        chk("b2b.T4.gnt", 64'(ma0.gnt), 64'd0);
        tick();
        #2;
        chk("b2b.T5.gnt",  64'(ma0.gnt),  64'd0);
        chk("b2b.T5.rvld", 64'(ma0.rvld), 64'd1);
        tick();
        #2;
        chk("b2b.T6.gnt",  64'(ma0.gnt), 64'd1);
        chk("b2b.T6.we",   64'(sa.we),   64'd1);
        chk("b2b.T6.addr", 64'(sa.addr), 64'h020C);
        tick();
        idle(0);
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
